// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: FSM state encoding and default frame
// constants. The MOSI receive path uses the same defaults.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    SHIFT  = 2'd2,
    DUMMY  = 2'd3
  } spi_state_e;

  localparam int   SPI_WIDTH      = 8;
  localparam logic SPI_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/miso_shift_tx_if.sv
// Parallel word handshake into the MISO transmit path.
// The producer drives tx_data/tx_valid; the transmitter drives tx_ready.
interface miso_shift_tx_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/spi_bit_counter.sv
// Frame bit counter shared by the SPI transmit and receive paths.
// wrap flags the increment that would reach WIDTH; the counter then
// returns to 0 instead, so a full frame always ends with count = 0.
module spi_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          wrap
);

  logic [CW-1:0] count_q;

  assign wrap  = inc && (count_q == CW'(WIDTH - 1));
  assign count = count_q;

  // Count strobes within a frame; clear has priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear || wrap) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/miso_shift_tx.sv
// SPI slave MISO transmit path: one-word holding buffer fed by a
// valid/ready handshake, shifted out MSB-first on each SCLK rising-edge
// strobe while cs_n is low.
// Optional build macro MISO_TRISTATE_EN adds miso_oe (registered !cs_n)
// and releases miso to high-impedance while miso_oe is low.
//
// state  | meaning
// IDLE   | no frame in progress, shift register holds nothing to send
// LOADED | word in shift register, MSB presented, no strobe seen yet
// SHIFT  | word partially shifted out
// DUMMY  | frame started with no data; counting strobes to stay aligned
module miso_shift_tx
  import spi_pkg::*;
#(
  parameter int   WIDTH      = SPI_WIDTH,
  parameter logic IDLE_LEVEL = SPI_IDLE_LEVEL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk_pos_edge,
  input  logic                  cs_n,
  miso_shift_tx_if.slave        tx_if,
  output logic                  miso,
  output logic                  frame_done,
  output logic                  underrun,
  output logic                  abort
`ifdef MISO_TRISTATE_EN
  ,
  output logic                  miso_oe
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  spi_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;
  logic             frame_done_q, frame_done_d;
  logic             underrun_q, underrun_d;
  logic             abort_q, abort_d;

  logic             strobe;
  logic             accept;
  logic             do_load;
  logic             cnt_clear;
  logic             cnt_inc;
  logic             cnt_wrap;
  logic [CW-1:0]    bit_cnt;
  logic             miso_int;

  assign strobe = sclk_pos_edge && !cs_n;
  assign accept = tx_if.tx_valid && !hold_full_q;

  spi_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (bit_cnt),
    .wrap  (cnt_wrap)
  );

  // Holding buffer: filled by the handshake, emptied by a transfer.
  // Accept needs empty and transfer needs full, so they never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (accept) begin
      hold_q      <= tx_if.tx_data;
      hold_full_q <= 1'b1;
    end else if (do_load) begin
      hold_full_q <= 1'b0;
    end
  end

  // State, shift register and event pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
      abort_q      <= abort_d;
    end
  end

  // Next-state logic; a strobe in IDLE wins over a pending transfer because
  // the master has already sampled the idle level for that bit.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    abort_d      = 1'b0;
    do_load      = 1'b0;
    cnt_clear    = 1'b0;
    cnt_inc      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (strobe) begin
          state_d    = DUMMY;
          underrun_d = 1'b1;
          cnt_inc    = 1'b1;
        end else if (hold_full_q) begin
          do_load = 1'b1;
        end
      end
      LOADED: begin
        cnt_clear = 1'b1;
        if (strobe) begin
          state_d   = SHIFT;
          shift_d   = {shift_q[WIDTH-2:0], 1'b0};
          cnt_clear = 1'b0;
          cnt_inc   = 1'b1;
        end else if (cs_n && hold_full_q) begin
          do_load = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_n) begin
          state_d   = IDLE;
          shift_d   = '0;
          abort_d   = 1'b1;
          cnt_clear = 1'b1;
        end else if (strobe) begin
          cnt_inc = 1'b1;
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          if (cnt_wrap) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
            do_load      = hold_full_q;
          end
        end
      end
      DUMMY: begin
        if (cs_n && (bit_cnt != '0)) begin
          state_d   = IDLE;
          cnt_clear = 1'b1;
        end else if (strobe) begin
          cnt_inc = 1'b1;
          if (cnt_wrap) begin
            state_d = IDLE;
            do_load = hold_full_q;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_clear = 1'b1;
      end
    endcase
    if (do_load) begin
      state_d = LOADED;
      shift_d = hold_q;
    end
  end

  // Output decode: data is presented only while a real word is in flight.
  always_comb begin
    miso_int = IDLE_LEVEL;
    if ((state_q == LOADED) || (state_q == SHIFT)) begin
      miso_int = shift_q[WIDTH-1];
    end
  end

  assign tx_if.tx_ready = !hold_full_q;
  assign frame_done     = frame_done_q;
  assign underrun       = underrun_q;
  assign abort          = abort_q;

`ifdef MISO_TRISTATE_EN
  logic miso_oe_q;

  // Output enable follows chip select one clock later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_oe_q <= 1'b0;
    end else begin
      miso_oe_q <= !cs_n;
    end
  end

  assign miso_oe = miso_oe_q;
  assign miso    = miso_oe_q ? miso_int : 1'bz;
`else
  assign miso = miso_int;
`endif

endmodule

// File: tb/tb_miso_shift_tx.sv
// Directed bench for miso_shift_tx (WIDTH=8, IDLE_LEVEL=0).
module tb_miso_shift_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk_pos_edge = 1'b0;
  logic cs_n = 1'b1;
  logic miso, frame_done, underrun, abort;
`ifdef MISO_TRISTATE_EN
  logic miso_oe;
`endif

  int n_checks = 0;
  int n_errors = 0;

  miso_shift_tx_if #(.WIDTH(8)) tx_if ();

  miso_shift_tx #(
    .WIDTH      (8),
    .IDLE_LEVEL (1'b0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sclk_pos_edge (sclk_pos_edge),
    .cs_n          (cs_n),
    .tx_if         (tx_if),
    .miso          (miso),
    .frame_done    (frame_done),
    .underrun      (underrun),
    .abort         (abort)
`ifdef MISO_TRISTATE_EN
    ,
    .miso_oe       (miso_oe)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    bit done = 0;
    tx_if.tx_data  = d;
    tx_if.tx_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (tx_if.tx_ready) done = 1;
      tick();
    end
    tx_if.tx_valid = 1'b0;
    check("write_accept", 32'(done), 32'd1);
  endtask

  task automatic strobe_check(input string tag, input logic exp_miso, input logic exp_done,
                              input logic exp_under, input logic exp_abort);
    sclk_pos_edge = 1'b1;
    tick();
    sclk_pos_edge = 1'b0;
    check({tag, "_miso"}, 32'(miso), 32'(exp_miso));
    check({tag, "_done"}, 32'(frame_done), 32'(exp_done));
    check({tag, "_under"}, 32'(underrun), 32'(exp_under));
    check({tag, "_abort"}, 32'(abort), 32'(exp_abort));
    tick();
  endtask

  // Expects the word already presented (LOADED, cs_n low for at least a cycle).
  task automatic run_frame(input string tag, input logic [7:0] w);
    logic em;
    check({tag, "_msb"}, 32'(miso), 32'(w[7]));
    for (int k = 1; k <= 8; k++) begin
      em = 1'b0;
      if (k < 8) em = w[7-k];
      strobe_check(tag, em, k == 8, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] pair;
    logic        em;
    tx_if.tx_data  = '0;
    tx_if.tx_valid = 1'b0;

    // reset state
    #12;
    check("rst_ready", 32'(tx_if.tx_ready), 32'd1);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_under", 32'(underrun), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
`ifdef MISO_TRISTATE_EN
    check("rst_oe", 32'(miso_oe), 32'd0);
    check("rst_miso_z", 32'(miso === 1'bz), 32'd1);
`else
    check("rst_miso", 32'(miso), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // 1: single word 0xA5
    write_word(8'hA5);
    check("t1_hold_full", 32'(tx_if.tx_ready), 32'd0);
    cs_n = 1'b0;
    tick();
    check("t1_ready", 32'(tx_if.tx_ready), 32'd1);
    run_frame("t1", 8'hA5);
    cs_n = 1'b1;
    tick();

    // 2: back-to-back 0x3C then 0xFF with no gap
    write_word(8'h3C);
    tick();
    cs_n = 1'b0;
    write_word(8'hFF);
    check("t2_ready_low", 32'(tx_if.tx_ready), 32'd0);
    pair = 16'h3CFF;
    check("t2_msb", 32'(miso), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      em = 1'b0;
      if (k < 16) em = pair[15-k];
      strobe_check("t2", em, (k == 8) || (k == 16), 1'b0, 1'b0);
      if (k == 8) check("t2_ready_after_xfer", 32'(tx_if.tx_ready), 32'd1);
    end
    cs_n = 1'b1;
    tick();

    // 3: underrun dummy frame, 0x81 written mid-frame starts afterwards
    cs_n = 1'b0;
    tick();
    for (int k = 1; k <= 8; k++) begin
      strobe_check("t3_dummy", k == 8, 1'b0, k == 1, 1'b0);
      if (k == 3) begin
        write_word(8'h81);
        check("t3_held", 32'(tx_if.tx_ready), 32'd0);
      end
    end
    run_frame("t3", 8'h81);
    cs_n = 1'b1;
    tick();

    // 4: abort after 3 bits of 0xF0, then clean 0x55
    write_word(8'hF0);
    tick();
    cs_n = 1'b0;
    tick();
    check("t4_msb", 32'(miso), 32'd1);
    for (int k = 1; k <= 3; k++) strobe_check("t4_part", 1'b1, 1'b0, 1'b0, 1'b0);
    cs_n = 1'b1;
    tick();
    check("t4_abort", 32'(abort), 32'd1);
    check("t4_no_done", 32'(frame_done), 32'd0);
    tick();
    check("t4_abort_pulse", 32'(abort), 32'd0);
    cs_n = 1'b0;
    tick();
    check("t4_idle_miso", 32'(miso), 32'd0);
    cs_n = 1'b1;
    write_word(8'h55);
    tick();
    cs_n = 1'b0;
    tick();
    run_frame("t4", 8'h55);
    cs_n = 1'b1;
    tick();

    // 5: async reset mid-shift of 0xC3 with a word pending
    write_word(8'hC3);
    tick();
    cs_n = 1'b0;
    tick();
    strobe_check("t5_part", 1'b1, 1'b0, 1'b0, 1'b0);
    strobe_check("t5_part", 1'b0, 1'b0, 1'b0, 1'b0);
    strobe_check("t5_part", 1'b0, 1'b0, 1'b0, 1'b0);
    strobe_check("t5_part", 1'b0, 1'b0, 1'b0, 1'b0);
    write_word(8'h99);
    check("t5_pending", 32'(tx_if.tx_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_ready", 32'(tx_if.tx_ready), 32'd1);
    check("t5_rst_done", 32'(frame_done), 32'd0);
    check("t5_rst_under", 32'(underrun), 32'd0);
    check("t5_rst_abort", 32'(abort), 32'd0);
`ifdef MISO_TRISTATE_EN
    check("t5_rst_oe", 32'(miso_oe), 32'd0);
`else
    check("t5_rst_miso", 32'(miso), 32'd0);
`endif
    cs_n = 1'b1;
    #2 rst = 1'b0;
    tick();
    write_word(8'h5A);
    tick();
    cs_n = 1'b0;
    tick();
    run_frame("t5", 8'h5A);
    cs_n = 1'b1;
    tick();

`ifdef MISO_TRISTATE_EN
    // 6: output enable follows !cs_n one clock later
    tick();
    check("t6_oe_off", 32'(miso_oe), 32'd0);
    check("t6_z", 32'(miso === 1'bz), 32'd1);
    cs_n = 1'b0;
    #1;
    check("t6_oe_lag", 32'(miso_oe), 32'd0);
    tick();
    check("t6_oe_on", 32'(miso_oe), 32'd1);
    check("t6_driven", 32'(miso), 32'd0);
    cs_n = 1'b1;
    tick();
    check("t6_oe_release", 32'(miso_oe), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/miso_shift_tx.md
Name: miso_shift_tx

Overview:
SPI slave transmit path, the MISO-side counterpart to the MOSI sampling flop. It accepts parallel words through a valid/ready handshake into a one-word holding buffer. It then shifts each word out MSB-first on the miso pin, advancing one bit per sclk_pos_edge strobe while cs_n is low. It sits beside the serial clock edge detector, which supplies the single-cycle strobe, and the MOSI receive path, which samples on the opposite edge.

Parameters:
WIDTH, 8, bits per SPI frame (valid range 2..32)
IDLE_LEVEL, 1'b0, miso value when no frame data is being presented

Ports:
clk  input  1  system clock; all logic on posedge clk
rst  input  1  asynchronous, active-high reset
sclk_pos_edge  input  1  one-clk strobe per SCLK rising edge, synchronous to clk
cs_n  input  1  chip select, active low, already synchronised to clk
tx_data  input  WIDTH  word to transmit
tx_valid  input  1  tx_data is valid
tx_ready  output  1  holding buffer empty; transfer occurs when tx_valid && tx_ready
miso  output  1  serial data out
frame_done  output  1  one-clk pulse when the last bit of a loaded word has been clocked out
underrun  output  1  one-clk pulse at the first strobe of a frame with no data loaded
abort  output  1  one-clk pulse when cs_n rises with a frame partially shifted

Behaviour:
- Reset values (async on rst high): state=IDLE, hold empty, shift register=0, bit counter=0, tx_ready=1, miso=IDLE_LEVEL, frame_done=0, underrun=0, abort=0.
- Handshake:
  - tx_ready = !hold_full, decoded from a register.
  - Accepting at cycle N sets hold_full at N+1.
  - There is no bypass into the shift register.
- Hold-to-shift transfer happens only at a frame boundary, defined as:
  - state IDLE, or
  - state LOADED with cs_n high.
  - The transfer moves hold into the shift register, clears hold_full and goes to LOADED.
  - When tx is accepted at cycle N with state IDLE, miso shows tx_data[WIDTH-1] from N+2.
- States:
  - IDLE: miso=IDLE_LEVEL. On a strobe with cs_n low: go DUMMY, pulse underrun, bit counter=1.
  - LOADED: miso=shift[WIDTH-1], bit counter=0. On a strobe with cs_n low: go SHIFT, shift left by one, bit counter=1.
  - SHIFT: miso=shift[WIDTH-1]. On each strobe with cs_n low: shift left and increment the counter.
    - On the strobe where the counter would reach WIDTH: pulse frame_done and reset the counter to 0.
    - Then, if hold is full, transfer in the same cycle and go LOADED; otherwise go IDLE.
  - DUMMY: miso=IDLE_LEVEL, counting strobes to keep frame alignment.
    - At WIDTH strobes: counter=0; transfer if hold is full (go LOADED), otherwise go IDLE.
    - No frame_done in this state.
- Bit timing: after k strobes in a frame, miso=word[WIDTH-1-k] for k=0..WIDTH-1.
- Strobes while cs_n is high are ignored.
- cs_n rising while in SHIFT, or in DUMMY with counter>0:
  - Discard the partial word and pulse abort (SHIFT only).
  - Go IDLE with counter=0.
  - Hold contents are kept; the next cycle may transfer them.
- Simultaneous tx accept and frame-end transfer: the transfer uses the old hold contents; the new word is accepted only if tx_ready was 1, i.e. hold was empty, so no overwrite is possible.
- Bit counter is $clog2(WIDTH+1) bits wide; no arithmetic beyond the increment/compare.

Optional Feature:
MISO_TRISTATE_EN
- Defined: adds output miso_oe (1 bit, reset 0), equal to !cs_n registered. While miso_oe=0, miso is driven 1'bz for board-level sharing.
- Undefined: no miso_oe port; miso is always driven as specified above.

Decomposition:
- Package spi_pkg holds:
  - the state enum {IDLE, LOADED, SHIFT, DUMMY}, 2 bits;
  - default constants SPI_WIDTH=8 and SPI_IDLE_LEVEL=0, shared with the MOSI receive path.
- One natural sub-module: spi_bit_counter, with inputs clear, inc and WIDTH and outputs count and wrap. It is reusable by the receiver.

Test Plan:
1. With cs_n high, write 0xA5, then drop cs_n and issue 8 strobes -> miso sequence 1,0,1,0,0,1,0,1, one per strobe; frame_done pulses on the 8th strobe; state goes IDLE.
2. Write 0x3C, then 0xFF while the first is shifting (tx_ready low until transfer) -> 16 continuous strobes give 00111100 11111111; frame_done pulses twice; no gap between words.
3. cs_n low with nothing written, 8 strobes -> underrun pulses once on the 1st strobe; miso=0 throughout; write 0x81 mid-dummy -> it starts only after the 8th strobe, as 1,0,0,0,0,0,0,1.
4. Write 0xF0, then 3 strobes, then raise cs_n -> abort pulses; no frame_done; miso=0; a subsequent write of 0x55 starts cleanly at bit 7.
5. Assert rst mid-SHIFT (after 4 bits of 0xC3) -> all outputs at reset values immediately (async); tx_ready=1; the next frame after reset starts from a new load.
6. With MISO_TRISTATE_EN defined -> miso is z with cs_n high and driven with cs_n low; miso_oe tracks !cs_n with 1-clk delay.
